io_mem_responder: RTL and testbench
===================================

IO_MEM_RESPONDER -- requirements
Module: io_mem_responder

Interface
REQ-001 Parameter: RX_FIFO_DEPTH, 4, receive byte FIFO entries (power of two, >=2).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 Addr  in  8  byte offset within IO region; only Addr[7:2] decoded.
REQ-005 StoreMaskIO  in  4  per-byte write enables from the memory map; nonzero = IO write this cycle.
REQ-006 LoadIO  in  1  IO read strobe this cycle.
REQ-007 WriteData  in  32  store data.
REQ-008 ReadData  out  32  registered load data, valid cycle after LoadIO.
REQ-009 InstrRetire  in  1  one instruction retired this cycle.
REQ-010 UARTRxData  in  8; UARTRxDataValid  in  1; UARTRxDataReady  out  1  receive byte handshake (push side).
REQ-011 UARTTxData  out  8; UARTTxDataValid  out  1; UARTTxDataReady  in  1  transmit byte handshake.

Function
REQ-012 Register map (offset): 0x00 RX status, bit0 = FIFO non-empty; 0x04 RX data, bits[7:0] = FIFO head, read pops; 0x08 TX status, bit0 = holding register empty; 0x0C TX data, write bits[7:0]; 0x10 cycle counter; 0x14 instruction counter; 0x18 counter clear (write-only); all other offsets and unused bits read 0.
REQ-013 Read latency exactly 1 cycle; ReadData reflects state before any update in the access cycle; ReadData holds its value when LoadIO=0.
REQ-014 RX push: entry written when UARTRxDataValid & UARTRxDataReady; UARTRxDataReady = not full (combinational from count).
REQ-015 RX pop: LoadIO at 0x04 with FIFO non-empty pops head; same read on empty FIFO returns 0, no pop, no pointer change.
REQ-016 Simultaneous push and pop on non-empty FIFO: count unchanged, order preserved; pointers wrap modulo RX_FIFO_DEPTH.
REQ-017 TX: write to 0x0C with StoreMaskIO[0]=1 and holding register empty loads byte and sets UARTTxDataValid next cycle; write while full is dropped silently.
REQ-018 UARTTxDataValid stays high, UARTTxData stable, until UARTTxDataValid & UARTTxDataReady; register empty next cycle.
REQ-019 TX write in the cycle the handshake completes is dropped (status still read full).
REQ-020 Cycle counter increments every cycle; instruction counter increments when InstrRetire=1; both 32-bit, wrap 0xFFFFFFFF -> 0.
REQ-021 Any write (nonzero StoreMaskIO) to 0x18 sets both counters to 0 next cycle; clear beats increment.
REQ-022 Writes to read-only offsets have no effect; StoreMaskIO and LoadIO in the same cycle both take effect.

Reset
REQ-023 On rst: FIFO empty, pointers 0, UARTRxDataReady=1 after reset, TX holding empty, UARTTxDataValid=0, UARTTxData=0, ReadData=0, both counters 0.
REQ-024 rst asserted mid-transfer discards pending TX byte and all FIFO contents; no handshake completes in a reset cycle.

Structure
REQ-025 Shared package holds register offset constants (0x00-0x18) and status bit positions.
REQ-026 RX buffer is sub-module io_rx_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification
REQ-027 Reset, read 0x00, 0x08, 0x10 -> 0, 1, small cycle count; UARTTxDataValid=0.
REQ-028 Push 0x41,0x42 via RX; read 0x04 twice -> 0x41, 0x42; third read -> 0, status 0x00 reads 0.
REQ-029 Push 4 bytes with no reads -> UARTRxDataReady=0, fifth byte held off; read once -> ready=1, fifth accepted in order.
REQ-030 Write 0x0C=0x55 with UARTTxDataReady=0 -> valid=1, data 0x55; second write 0x66 dropped; raise ready -> one handshake, status 0x08 reads 1.
REQ-031 Pulse InstrRetire 10 times, read 0x14 -> 10; write 0x18 -> next reads of 0x10/0x14 return 0 plus elapsed cycles / 0.
REQ-032 Force cycle counter to 0xFFFFFFFF (run or preload) -> next cycle reads 0; simultaneous push/pop on 2-entry FIFO keeps count 2.

Source files
------------

// File: rtl/io_mem_responder_pkg.sv
// Shared definitions for the IO memory-mapped responder: register offsets,
// their decoded word indices and the status bit positions.
package io_mem_responder_pkg;

   localparam logic [7:0] OFF_RX_STATUS = 8'h00;
   localparam logic [7:0] OFF_RX_DATA   = 8'h04;
   localparam logic [7:0] OFF_TX_STATUS = 8'h08;
   localparam logic [7:0] OFF_TX_DATA   = 8'h0C;
   localparam logic [7:0] OFF_CYCLE     = 8'h10;
   localparam logic [7:0] OFF_INSTR     = 8'h14;
   localparam logic [7:0] OFF_CLEAR     = 8'h18;

   localparam logic [5:0] IDX_RX_STATUS = OFF_RX_STATUS[7:2];
   localparam logic [5:0] IDX_RX_DATA   = OFF_RX_DATA[7:2];
   localparam logic [5:0] IDX_TX_STATUS = OFF_TX_STATUS[7:2];
   localparam logic [5:0] IDX_TX_DATA   = OFF_TX_DATA[7:2];
   localparam logic [5:0] IDX_CYCLE     = OFF_CYCLE[7:2];
   localparam logic [5:0] IDX_INSTR     = OFF_INSTR[7:2];
   localparam logic [5:0] IDX_CLEAR     = OFF_CLEAR[7:2];

   localparam int RX_NONEMPTY_BIT = 0;
   localparam int TX_EMPTY_BIT    = 0;

endpackage

// File: rtl/io_rx_fifo.sv
// Small synchronous FIFO buffering received UART bytes until software reads
// them. Depth must be a power of two so the pointers wrap naturally.
module io_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Storage array has no reset; only the pointers and count define contents
   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count alone
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/io_mem_responder.sv
// Memory-mapped IO responder: UART receive FIFO and transmit holding
// register, free-running cycle and retired-instruction counters, and a
// one-cycle registered read port.
module io_mem_responder
   import io_mem_responder_pkg::*;
#(
   parameter int RX_FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  Addr,
   input  logic [3:0]  StoreMaskIO,
   input  logic        LoadIO,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   input  logic        InstrRetire,
   input  logic [7:0]  UARTRxData,
   input  logic        UARTRxDataValid,
   output logic        UARTRxDataReady,
   output logic [7:0]  UARTTxData,
   output logic        UARTTxDataValid,
   input  logic        UARTTxDataReady
);

   logic [5:0]                       word;
   logic                             store_any;
   logic                             rx_pop;
   logic [7:0]                       rx_head;
   logic                             rx_full;
   logic                             rx_empty;
   logic [$clog2(RX_FIFO_DEPTH):0]   rx_count;
   logic                             tx_valid;
   logic [7:0]                       tx_data;
   logic                             tx_write;
   logic                             tx_done;
   logic                             counter_clear;
   logic [31:0]                      cycle_count;
   logic [31:0]                      instr_count;
   logic [31:0]                      read_next;
   logic                             unused_bits;

   assign word            = Addr[7:2];
   assign store_any       = |StoreMaskIO;
   assign rx_pop          = LoadIO && (word == IDX_RX_DATA);
   assign tx_write        = StoreMaskIO[0] && (word == IDX_TX_DATA);
   assign tx_done         = tx_valid && UARTTxDataReady;
   assign counter_clear   = store_any && (word == IDX_CLEAR);
   assign UARTRxDataReady = ~rx_full;
   assign UARTTxData      = tx_data;
   assign UARTTxDataValid = tx_valid;
   assign unused_bits     = &{1'b0, Addr[1:0], WriteData[31:8], rx_count};

   io_rx_fifo #(
      .WIDTH (8),
      .DEPTH (RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (UARTRxDataValid),
      .push_data (UARTRxData),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   // Decode the register being read from current (pre-update) state
   always_comb begin
      read_next = '0;
      case (word)
         IDX_RX_STATUS: read_next[RX_NONEMPTY_BIT] = ~rx_empty;
         IDX_RX_DATA:   if (!rx_empty) read_next[7:0] = rx_head;
         IDX_TX_STATUS: read_next[TX_EMPTY_BIT] = ~tx_valid;
         IDX_CYCLE:     read_next = cycle_count;
         IDX_INSTR:     read_next = instr_count;
         default:       read_next = '0;
      endcase
   end

   // Read data register updates only on a load and holds otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         ReadData <= '0;
      end else if (LoadIO) begin
         ReadData <= read_next;
      end
   end

   // Transmit holding register; a write landing in the handshake cycle is dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_valid <= 1'b0;
         tx_data  <= '0;
      end else if (tx_done) begin
         tx_valid <= 1'b0;
      end else if (tx_write && !tx_valid) begin
         tx_valid <= 1'b1;
         tx_data  <= WriteData[7:0];
      end
   end

   // Performance counters; a clear write takes priority over counting
   always_ff @(posedge clk) begin
      if (rst || counter_clear) begin
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (InstrRetire) begin
            instr_count <= instr_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_io_mem_responder.sv
// Directed self-checking bench for io_mem_responder. Expected read data is
// queued when a load is issued and popped when ReadData is sampled.
module tb_io_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  Addr;
   logic [3:0]  StoreMaskIO;
   logic        LoadIO;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        InstrRetire;
   logic [7:0]  UARTRxData;
   logic        UARTRxDataValid;
   logic        UARTRxDataReady;
   logic [7:0]  UARTTxData;
   logic        UARTTxDataValid;
   logic        UARTTxDataReady;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] expq[$];
   string       tagq[$];
   logic [7:0]  rxq[$];
   logic [31:0] cycModel;
   logic [31:0] instrModel;
   logic [31:0] lastExp;
   bit          wrapPending = 1'b0;
   bit          txHeld = 1'b0;
   int          hsCount = 0;
   logic [7:0]  hsData = 8'h00;
   int          hsBefore;

   always #5 clk = ~clk;

   io_mem_responder #(.RX_FIFO_DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .Addr            (Addr),
      .StoreMaskIO     (StoreMaskIO),
      .LoadIO          (LoadIO),
      .WriteData       (WriteData),
      .ReadData        (ReadData),
      .InstrRetire     (InstrRetire),
      .UARTRxData      (UARTRxData),
      .UARTRxDataValid (UARTRxDataValid),
      .UARTRxDataReady (UARTRxDataReady),
      .UARTTxData      (UARTTxData),
      .UARTTxDataValid (UARTTxDataValid),
      .UARTTxDataReady (UARTTxDataReady)
   );

   // Reference counters built only from the bench's own stimulus
   always @(posedge clk) begin
      if (rst) begin
         cycModel   <= 32'h0;
         instrModel <= 32'h0;
      end else if ((|StoreMaskIO) && (Addr[7:2] == 6'd6)) begin
         cycModel   <= 32'h0;
         instrModel <= 32'h0;
      end else begin
         cycModel   <= wrapPending ? 32'h0 : cycModel + 32'd1;
         instrModel <= instrModel + {31'b0, InstrRetire};
      end
   end

   // Count transmit handshakes, observed mid-cycle while both sides are stable
   always @(negedge clk) begin
      if (!rst && UARTTxDataValid && UARTTxDataReady) begin
         hsCount = hsCount + 1;
         hsData  = UARTTxData;
      end
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [3:0] m,
                                input logic [31:0] wd, input logic ld);
      Addr        = a;
      StoreMaskIO = m;
      WriteData   = wd;
      LoadIO      = ld;
      @(posedge clk);
      #1;
      StoreMaskIO = 4'h0;
      LoadIO      = 1'b0;
   endtask

   task automatic checkOutput();
      logic [31:0] e;
      string       t;
      e = expq.pop_front();
      t = tagq.pop_front();
      lastExp = e;
      checkVal(t, ReadData, e);
   endtask

   task automatic readReg(input logic [7:0] a, input string tag);
      logic [31:0] e;
      e = '0;
      case (a)
         8'h00: e[0] = (rxq.size() != 0);
         8'h04: if (rxq.size() != 0) e[7:0] = rxq.pop_front();
         8'h08: e[0] = ~txHeld;
         8'h10: e = cycModel;
         8'h14: e = instrModel;
         default: e = '0;
      endcase
      expq.push_back(e);
      tagq.push_back(tag);
      applyStimulus(a, 4'h0, 32'h0, 1'b1);
      checkOutput();
   endtask

   task automatic rxPush(input logic [7:0] d, input string tag);
      logic rdy;
      logic accepted;
      accepted        = 1'b0;
      UARTRxData      = d;
      UARTRxDataValid = 1'b1;
      for (int i = 0; i < 20 && !accepted; i++) begin
         rdy = UARTRxDataReady;
         @(posedge clk);
         #1;
         if (rdy) accepted = 1'b1;
      end
      UARTRxDataValid = 1'b0;
      if (accepted) rxq.push_back(d);
      checkVal(tag, {31'b0, accepted}, 32'h1);
   endtask

   initial begin
      rst = 1'b1; Addr = 8'h0; StoreMaskIO = 4'h0; LoadIO = 1'b0; WriteData = 32'h0;
      InstrRetire = 1'b0; UARTRxData = 8'h0; UARTRxDataValid = 1'b0; UARTTxDataReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset state");
      checkVal("reset_readdata", ReadData, 32'h0);
      checkVal("reset_tx_valid", {31'b0, UARTTxDataValid}, 32'h0);
      checkVal("reset_tx_data", {24'b0, UARTTxData}, 32'h0);
      checkVal("reset_rx_ready", {31'b0, UARTRxDataReady}, 32'h1);
      readReg(8'h00, "rx_status_reset");
      readReg(8'h08, "tx_status_reset");
      readReg(8'h10, "cycle_after_reset");
      @(posedge clk);
      #1;
      checkVal("readdata_hold", ReadData, lastExp);

      $display("[TB] rx basic push and pop");
      rxPush(8'h41, "rx_push_41");
      rxPush(8'h42, "rx_push_42");
      readReg(8'h04, "rx_data_41");
      readReg(8'h04, "rx_data_42");
      readReg(8'h04, "rx_data_empty");
      readReg(8'h00, "rx_status_empty");

      $display("[TB] rx fifo full back-pressure");
      rxPush(8'h43, "rx_push_43");
      rxPush(8'h44, "rx_push_44");
      rxPush(8'h45, "rx_push_45");
      rxPush(8'h46, "rx_push_46");
      checkVal("rx_ready_full", {31'b0, UARTRxDataReady}, 32'h0);
      UARTRxData = 8'h47; UARTRxDataValid = 1'b1;
      @(posedge clk);
      #1;
      checkVal("rx_fifth_held", {31'b0, UARTRxDataReady}, 32'h0);
      readReg(8'h04, "rx_pop_when_full");
      checkVal("rx_ready_after_pop", {31'b0, UARTRxDataReady}, 32'h1);
      @(posedge clk);
      #1;
      rxq.push_back(8'h47);
      UARTRxDataValid = 1'b0;
      checkVal("rx_ready_refull", {31'b0, UARTRxDataReady}, 32'h0);
      for (int i = 0; i < 4; i++) readReg(8'h04, "rx_drain_order");
      readReg(8'h00, "rx_status_drained");

      $display("[TB] tx holding register");
      applyStimulus(8'h0C, 4'h2, 32'h0000_0011, 1'b0);
      checkVal("tx_mask_bit0_needed", {31'b0, UARTTxDataValid}, 32'h0);
      applyStimulus(8'h0C, 4'h1, 32'hABCD_EF55, 1'b0);
      txHeld = 1'b1;
      checkVal("tx_valid_set", {31'b0, UARTTxDataValid}, 32'h1);
      checkVal("tx_data_55", {24'b0, UARTTxData}, 32'h55);
      applyStimulus(8'h0C, 4'hF, 32'h0000_0066, 1'b0);
      checkVal("tx_drop_when_full", {24'b0, UARTTxData}, 32'h55);
      readReg(8'h08, "tx_status_full");
      hsBefore = hsCount;
      UARTTxDataReady = 1'b1;
      @(posedge clk);
      #1;
      UARTTxDataReady = 1'b0;
      txHeld = 1'b0;
      checkVal("tx_valid_cleared", {31'b0, UARTTxDataValid}, 32'h0);
      checkVal("tx_one_handshake", hsCount, hsBefore + 1);
      checkVal("tx_handshake_data", {24'b0, hsData}, 32'h55);
      readReg(8'h08, "tx_status_empty");

      $display("[TB] tx write during handshake");
      applyStimulus(8'h0C, 4'h1, 32'h0000_0077, 1'b0);
      UARTTxDataReady = 1'b1;
      applyStimulus(8'h0C, 4'h1, 32'h0000_0088, 1'b0);
      UARTTxDataReady = 1'b0;
      checkVal("tx_hs_write_dropped", {31'b0, UARTTxDataValid}, 32'h0);
      checkVal("tx_hs_data_77", {24'b0, hsData}, 32'h77);
      readReg(8'h08, "tx_status_after_hs");

      $display("[TB] counters");
      for (int i = 0; i < 10; i++) begin
         InstrRetire = 1'b1;
         @(posedge clk);
         #1;
         InstrRetire = 1'b0;
         @(posedge clk);
         #1;
      end
      readReg(8'h14, "instr_count_ten");
      applyStimulus(8'h10, 4'hF, 32'h0000_0000, 1'b0);
      readReg(8'h10, "cycle_ro_write");
      InstrRetire = 1'b1;
      applyStimulus(8'h18, 4'h8, 32'h0, 1'b0);
      InstrRetire = 1'b0;
      readReg(8'h10, "cycle_after_clear");
      readReg(8'h14, "instr_after_clear");
      readReg(8'h1C, "unmapped_offset");

      $display("[TB] cycle counter wrap");
      force dut.cycle_count = 32'hFFFF_FFFF;
      wrapPending = 1'b1;
      #1;
      release dut.cycle_count;
      @(posedge clk);
      #1;
      wrapPending = 1'b0;
      readReg(8'h10, "cycle_wrap");

      $display("[TB] simultaneous push and pop");
      rxPush(8'h31, "rx_push_31");
      rxPush(8'h32, "rx_push_32");
      UARTRxData = 8'h33; UARTRxDataValid = 1'b1;
      readReg(8'h04, "rx_pushpop_head");
      rxq.push_back(8'h33);
      UARTRxDataValid = 1'b0;
      readReg(8'h00, "rx_pushpop_status");
      readReg(8'h04, "rx_pushpop_32");
      readReg(8'h04, "rx_pushpop_33");
      readReg(8'h04, "rx_pushpop_empty");

      $display("[TB] reset mid-transfer");
      applyStimulus(8'h0C, 4'h1, 32'h0000_0099, 1'b0);
      rxPush(8'h51, "rx_push_51");
      readReg(8'h10, "cycle_before_reset");
      hsBefore = hsCount;
      UARTTxDataReady = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      UARTTxDataReady = 1'b0;
      rxq.delete();
      txHeld = 1'b0;
      checkVal("rst_tx_valid", {31'b0, UARTTxDataValid}, 32'h0);
      checkVal("rst_tx_data", {24'b0, UARTTxData}, 32'h0);
      checkVal("rst_readdata", ReadData, 32'h0);
      checkVal("rst_rx_ready", {31'b0, UARTRxDataReady}, 32'h1);
      checkVal("rst_no_handshake", hsCount, hsBefore);
      readReg(8'h00, "rst_rx_status");
      readReg(8'h04, "rst_rx_data");
      readReg(8'h10, "rst_cycle_count");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
